// File: rtl/srl_sra_pipe32_pkg.sv
// Shared definitions for the pipelined right shifter: operand widths,
// shift-op encoding and the fill-bit helper used at pipeline entry.
package srl_sra_pipe32_pkg;

  localparam int SHAMT_W    = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_STAGES = SHAMT_W;

  typedef enum logic {
    OP_SRL = 1'b0,
    OP_SRA = 1'b1
  } shift_op_e;

  // Bit shifted in from the left: sign bit for sra, zero for srl.
  function automatic logic fill_bit(input shift_op_e op, input logic [DATA_W-1:0] d);
    return (op == OP_SRA) ? d[DATA_W-1] : 1'b0;
  endfunction

endpackage

// File: rtl/srl_sra_pipe32_stage.sv
// One pipeline stage of the right shifter: a conditional shift by DIST
// followed by the stage register. The fill bit travels with the operand so
// every stage shifts in the same bit the first stage captured.
import srl_sra_pipe32_pkg::*;

module shift_right_stage #(
  parameter int DIST  = 16,
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               en,
  input  logic               in_valid,
  input  logic               in_sel,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_fill,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_fill,
  output logic [TAG_W-1:0]   out_tag
);

  logic               valid_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic               fill_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [DATA_W-1:0]  shifted_next;

  // Shift by DIST when this stage's shamt bit is set, otherwise pass through.
  always_comb begin
    shifted_next = in_data;
    if (in_sel) begin
      shifted_next = {{DIST{in_fill}}, in_data[DATA_W-1:DIST]};
    end
  end

  // Stage register: reset clears everything, flush kills only the valid,
  // and a stalled pipe simply holds its contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      shamt_reg <= '0;
      fill_reg  <= 1'b0;
      tag_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (en) begin
      valid_reg <= in_valid;
      data_reg  <= shifted_next;
      shamt_reg <= in_shamt;
      fill_reg  <= in_fill;
      tag_reg   <= in_tag;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_shamt = shamt_reg;
  assign out_fill  = fill_reg;
  assign out_tag   = tag_reg;

endmodule

// File: rtl/srl_sra_pipe32.sv
// Pipelined 32-bit right barrel shifter (srl/sra) with valid/ready on both
// sides. Five stages shift by 16, 8, 4, 2, 1; the whole pipe stalls as one
// when the consumer is not ready, and flush drops everything in flight.
import srl_sra_pipe32_pkg::*;

module srl_sra_pipe32 #(
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Index 0 is the pipe input, index k+1 is the output of stage k.
  logic               valid_s [NUM_STAGES+1];
  logic [DATA_W-1:0]  data_s  [NUM_STAGES+1];
  logic [SHAMT_W-1:0] shamt_s [NUM_STAGES+1];
  logic               fill_s  [NUM_STAGES+1];
  logic [TAG_W-1:0]   tag_s   [NUM_STAGES+1];

  logic stall;
  logic stage_en;

  // Global stall: a result waiting at the output freezes every stage.
  always_comb begin
    stall    = valid_s[NUM_STAGES] & ~out_ready;
    stage_en = ~stall;
    in_ready = ~stall & ~flush & ~reset;
  end

  assign valid_s[0] = in_valid & in_ready;
  assign data_s[0]  = in_data;
  assign shamt_s[0] = in_shamt;
  assign fill_s[0]  = fill_bit(shift_op_e'(in_arith), in_data);
  assign tag_s[0]   = in_tag;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      shift_right_stage #(
        .DIST  (1 << (NUM_STAGES - 1 - gi)),
        .TAG_W (TAG_W)
      ) u_stage (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .en        (stage_en),
        .in_valid  (valid_s[gi]),
        .in_sel    (shamt_s[gi][SHAMT_W-1-gi]),
        .in_data   (data_s[gi]),
        .in_shamt  (shamt_s[gi]),
        .in_fill   (fill_s[gi]),
        .in_tag    (tag_s[gi]),
        .out_valid (valid_s[gi+1]),
        .out_data  (data_s[gi+1]),
        .out_shamt (shamt_s[gi+1]),
        .out_fill  (fill_s[gi+1]),
        .out_tag   (tag_s[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_s[NUM_STAGES];
  assign out_data  = data_s[NUM_STAGES];
  assign out_tag   = tag_s[NUM_STAGES];

endmodule

// File: tb/tb_srl_sra_pipe32.sv
// Directed bench for srl_sra_pipe32: latency, shift results, back-to-back
// throughput, stall hold, flush and reset-during-stall.
module tb_srl_sra_pipe32;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data [5];
  logic [4:0]  exp_tag  [5];

  srl_sra_pipe32 #(.TAG_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] d, input logic [4:0] s, input logic a, input logic [4:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_arith = a;
    in_tag   = t;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] s, input logic a, input logic [4:0] t);
    present(d, s, a, t);
    step();
  endtask

  // One isolated op: accepted, invisible for 4 cycles, out on the 5th, then gone.
  task automatic run_single(input string name, input logic [31:0] d, input logic [4:0] s,
                            input logic a, input logic [4:0] t, input logic [31:0] exp);
    out_ready = 1'b1;
    present(d, s, a, t);
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
      step();
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    $display("txn %s tag=%0d data=0x%08h", name, out_tag, out_data);
    step();
    chk({name, "_gone"}, 32'(out_valid), 32'd0);
  endtask

  // Check the five queued results leave on consecutive cycles in order.
  task automatic drain5(input string name);
    for (int j = 0; j < 5; j++) begin
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, out_data, exp_data[j]);
      chk({name, "_tag"}, 32'(out_tag), 32'(exp_tag[j]));
      $display("txn %s tag=%0d data=0x%08h", name, out_tag, out_data);
      step();
    end
    chk({name, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_high", 32'(in_ready), 32'd1);
    step();

    // 1. latency and srl by 31
    run_single("srl31", 32'h8000_0000, 5'd31, 1'b0, 5'd3, 32'h0000_0001);

    // 2. sign fill and zero fill
    run_single("sra4_neg", 32'h8000_0000, 5'd4, 1'b1, 5'd4, 32'hF800_0000);
    run_single("sra4_pos", 32'h7FFF_FFF0, 5'd4, 1'b1, 5'd5, 32'h07FF_FFFF);
    run_single("srl16", 32'hFFFF_FFFF, 5'd16, 1'b0, 5'd6, 32'h0000_FFFF);

    // 3. five back-to-back ops on 0xF0000000
    exp_data[0] = 32'hF000_0000; exp_data[1] = 32'hF800_0000; exp_data[2] = 32'h3C00_0000;
    exp_data[3] = 32'hFE00_0000; exp_data[4] = 32'h0F00_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_tag[i] = 5'(10 + i);
      push(32'hF000_0000, 5'(i), 1'(i % 2), exp_tag[i]);
    end
    in_valid = 1'b0;
    drain5("b2b");

    // 4. full pipe, consumer stalls for 3 cycles
    exp_data[0] = 32'hD2D2_D2D2; exp_data[1] = 32'h52D2_D2D2; exp_data[2] = 32'h00A5_A5A5;
    exp_data[3] = 32'hFFA5_A5A5; exp_data[4] = 32'h0001_2345;
    for (int i = 0; i < 5; i++) exp_tag[i] = 5'(20 + i);
    push(32'hA5A5_A5A5, 5'd1, 1'b1, exp_tag[0]);
    push(32'hA5A5_A5A5, 5'd1, 1'b0, exp_tag[1]);
    push(32'hA5A5_A5A5, 5'd8, 1'b0, exp_tag[2]);
    push(32'hA5A5_A5A5, 5'd8, 1'b1, exp_tag[3]);
    push(32'h1234_5678, 5'd12, 1'b1, exp_tag[4]);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, exp_data[0]);
      chk("stall_tag", 32'(out_tag), 32'(exp_tag[0]));
      step();
    end
    out_ready = 1'b1;
    #1;
    drain5("stall_drain");

    // 5. flush with 3 ops in flight and a new op offered
    push(32'h1111_1111, 5'd1, 1'b0, 5'd1);
    push(32'h2222_2222, 5'd2, 1'b0, 5'd2);
    push(32'h3333_3333, 5'd3, 1'b0, 5'd3);
    present(32'h4444_4444, 5'd4, 1'b0, 5'd9);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_quiet", 32'(out_valid), 32'd0);
      step();
    end
    run_single("post_flush", 32'hDEAD_BEEF, 5'd20, 1'b1, 5'd7, 32'hFFFF_FDEA);

    // 6. reset pulse while stalled
    for (int i = 0; i < 5; i++) push(32'hCAFE_0000, 5'(i), 1'b1, 5'(i));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("pre_rst_stall_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    run_single("srl0", 32'h1234_5678, 5'd0, 1'b0, 5'd12, 32'h1234_5678);
    run_single("sra0", 32'h1234_5678, 5'd0, 1'b1, 5'd13, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
